// File: rtl/adder_share_pkg.sv
// Shared definitions for the adder-sharing arbiter slice.
package adder_share_pkg;

    localparam int unsigned ADDER_WIDTH = 32;
    localparam int unsigned MAX_REQ     = 8;
    localparam int unsigned MAX_ID_W    = $clog2(MAX_REQ);

    // Operand bundle as captured into the first pipeline stage
    typedef struct packed {
        logic [ADDER_WIDTH-1:0] a;
        logic [ADDER_WIDTH-1:0] b;
        logic [MAX_ID_W-1:0]    id;
    } op_t;

    // Result bundle as held in the second pipeline stage
    typedef struct packed {
        logic [ADDER_WIDTH-1:0] sum;
        logic                   cout;
        logic [MAX_ID_W-1:0]    id;
    } rsp_t;

endpackage

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches from a rotating pointer, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            advance_en,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_idx
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] cand;
    logic            found;

    // First asserted request at or after the pointer wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = ID_W'((32'(ptr_q) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Pointer moves past the winner only when the grant is actually taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance_en && (|req)) begin
            ptr_q <= ID_W'((32'(grant_idx) + 1) % N);
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// One registered adder shared by NUM_REQ requesters through a round-robin
// arbiter and a two-stage pipeline (operands, then result) with backpressure.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = ADDER_WIDTH,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [ID_W-1:0]  id;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic [ID_W-1:0]  id;
    } s2_t;

    logic               s1_valid;
    logic               s2_valid;
    s1_t                s1_q;
    s2_t                s2_q;
    logic               advance;
    logic               accept_ok;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [WIDTH:0]     full_sum;

    assign advance   = !s2_valid || rsp_ready;
    assign accept_ok = (!s1_valid || advance) && rst_n;
    assign req_ready = grant & {NUM_REQ{accept_ok}};

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req_valid),
        .advance_en (accept_ok),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // Operand mux driven by the one-hot grant
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Shared adder between S1 and S2, carry kept as the top bit
    always_comb begin
        full_sum = {1'b0, s1_q.a} + {1'b0, s1_q.b};
    end

    // S1: load on a transfer, otherwise empty out when its contents move to S2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (accept_ok && (|req_valid)) begin
            s1_valid <= 1'b1;
            s1_q.a   <= sel_a;
            s1_q.b   <= sel_b;
            s1_q.id  <= grant_idx;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    // S2: takes S1's result whenever it is free or being popped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_q.sum  <= full_sum[WIDTH-1:0];
                s2_q.cout <= full_sum[WIDTH];
                s2_q.id   <= s1_q.id;
            end
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_id    = s2_q.id;
    assign rsp_sum   = s2_q.sum;
    assign rsp_cout  = s2_q.cout;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: inputs change #1 after the rising
// edge, outputs are observed on the falling edge.
module tb_adder_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    typedef struct packed {
        logic [W-1:0]  sum;
        logic          cout;
        logic [IW-1:0] id;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           model_ptr = 0;
    logic [N-1:0] vld;
    logic         rdy;
    logic [W-1:0] a_v[N];
    logic [W-1:0] b_v[N];
    logic [W-1:0] last_sum;
    logic         last_cout;

    adder_share_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (W),
        .ID_W    (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply();
        req_valid = vld;
        rsp_ready = rdy;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = a_v[i];
            req_b[i*W +: W] = b_v[i];
        end
    endtask

    // One clock: drive, observe at negedge, update model, return at posedge+1
    task automatic step();
        int           win;
        int           outstanding;
        logic         exp_any;
        logic [N-1:0] onehot;
        logic [N-1:0] xfer;
        logic [W:0]   s;
        exp_t         e;
        exp_t         h;
        apply();
        @(negedge clk);
        outstanding = sb.size();
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("rsp_spurious", 64'(rsp_valid), 64'(0));
            end else begin
                h = sb[0];
                check("rsp_sum", 64'(rsp_sum), 64'(h.sum));
                check("rsp_cout", 64'(rsp_cout), 64'(h.cout));
                check("rsp_id", 64'(rsp_id), 64'(h.id));
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    last_sum  = rsp_sum;
                    last_cout = rsp_cout;
                end
            end
        end
        win = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (model_ptr + k) % N;
            if (win < 0 && vld[idx]) win = idx;
        end
        exp_any = (vld != '0) && (rdy || outstanding < 2);
        check("req_ready_any", 64'(|req_ready), 64'(exp_any));
        if (exp_any) begin
            onehot = '0;
            onehot[win] = 1'b1;
            check("req_ready_grant", 64'(req_ready), 64'(onehot));
        end
        xfer = req_valid & req_ready;
        for (int i = 0; i < N; i++) begin
            if (xfer[i]) begin
                s      = {1'b0, a_v[i]} + {1'b0, b_v[i]};
                e.sum  = s[W-1:0];
                e.cout = s[W];
                e.id   = IW'(i);
                sb.push_back(e);
                model_ptr = (i + 1) % N;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        vld = '0;
        rdy = 1'b1;
        for (int i = 0; i < 12 && sb.size() > 0; i++) step();
        check(tag, 64'(sb.size()), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        vld   = '1;
        rdy   = 1'b1;
        for (int i = 0; i < N; i++) begin
            a_v[i] = 32'(i + 1);
            b_v[i] = 32'(100 * (i + 1));
        end
        apply();
        #3;
        check("reset_req_ready", 64'(req_ready), 64'(0));
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_rsp_id", 64'(rsp_id), 64'(0));
        check("reset_rsp_sum", 64'(rsp_sum), 64'(0));
        check("reset_rsp_cout", 64'(rsp_cout), 64'(0));
        vld = '0;
        apply();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request, two-edge latency
        vld = 4'b0001;
        a_v[0] = 32'd5;
        b_v[0] = 32'd7;
        step();
        check("lat_after_t", 64'(rsp_valid), 64'(0));
        vld = '0;
        step();
        check("lat_after_t1", 64'(rsp_valid), 64'(1));
        check("single_sum", 64'(rsp_sum), 64'(12));
        check("single_id", 64'(rsp_id), 64'(0));
        check("single_cout", 64'(rsp_cout), 64'(0));
        drain("single_drained");

        // Carry-out wrap cases
        vld = 4'b0010;
        a_v[1] = 32'hFFFF_FFFF;
        b_v[1] = 32'h0000_0001;
        step();
        drain("wrap1_drained");
        check("wrap1_sum", 64'(last_sum), 64'(0));
        check("wrap1_cout", 64'(last_cout), 64'(1));
        vld = 4'b0100;
        a_v[2] = 32'h8000_0000;
        b_v[2] = 32'h8000_0000;
        step();
        drain("wrap2_drained");
        check("wrap2_sum", 64'(last_sum), 64'(0));
        check("wrap2_cout", 64'(last_cout), 64'(1));

        // Round-robin with all requesters busy
        for (int i = 0; i < N; i++) begin
            a_v[i] = 32'(16 * i + 3);
            b_v[i] = 32'(1000 + i);
        end
        vld = '1;
        for (int c = 0; c < 8; c++) step();
        drain("rr_drained");

        // Backpressure mid-stream
        vld = '1;
        step();
        rdy = 1'b0;
        for (int c = 0; c < 5; c++) step();
        drain("bp_drained");

        // Asynchronous reset with both stages full
        vld = '1;
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) step();
        check("pre_reset_full", 64'(sb.size()), 64'(2));
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("midrst_req_ready", 64'(req_ready), 64'(0));
        check("midrst_rsp_sum", 64'(rsp_sum), 64'(0));
        check("midrst_rsp_id", 64'(rsp_id), 64'(0));
        sb.delete();
        model_ptr = 0;
        vld = '0;
        rdy = 1'b1;
        apply();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vld = 4'b1100;
        step();
        drain("post_reset_drained");

        // Random soak
        for (int c = 0; c < 10000; c++) begin
            vld = N'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                a_v[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                b_v[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            end
            step();
        end
        drain("soak_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
